// File: rtl/neighbor_scan_pkg.sv
// Shared board constants, coordinate type, FSM states and the
// neighbour offset table walked by neighbor_scan.
package neighbor_scan_pkg;

    localparam int unsigned BOARD_DIM = 8;

    typedef logic [2:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SCAN,
        DONE
    } state_t;

    // drow/dcol are two's complement in -1..+1
    typedef struct packed {
        logic [1:0] drow;
        logic [1:0] dcol;
    } offset_t;

    localparam offset_t OFFSETS [8] = '{
        '{2'b11, 2'b11},
        '{2'b11, 2'b00},
        '{2'b11, 2'b01},
        '{2'b00, 2'b11},
        '{2'b00, 2'b01},
        '{2'b01, 2'b11},
        '{2'b01, 2'b00},
        '{2'b01, 2'b01}
    };

endpackage

// File: rtl/neighbor_scan_offset.sv
// Combinational map from (scan index, cell) to the neighbour coordinate
// and whether that neighbour lies on the board.
module neighbor_offset
    import neighbor_scan_pkg::*;
#(
    parameter int unsigned DIM = BOARD_DIM
) (
    input  logic [2:0] index,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic [2:0] nb_row,
    output logic [2:0] nb_col,
    output logic       in_bounds
);

    offset_t    off;
    logic [4:0] r_ext;
    logic [4:0] c_ext;

    // A -1 step from 0 wraps to a large 5-bit value, so one unsigned
    // compare catches both edges of the board.
    always_comb begin
        off       = OFFSETS[index];
        r_ext     = {2'b00, row} + {{3{off.drow[1]}}, off.drow};
        c_ext     = {2'b00, col} + {{3{off.dcol[1]}}, off.dcol};
        in_bounds = (r_ext < 5'(DIM)) && (c_ext < 5'(DIM));
        nb_row    = r_ext[2:0];
        nb_col    = c_ext[2:0];
    end

endmodule

// File: rtl/neighbor_scan.sv
// Counts the mines adjacent to one board cell, one neighbour per cycle,
// working entirely from a snapshot of the request taken at start.
module neighbor_scan
    import neighbor_scan_pkg::*;
#(
    parameter int unsigned DIM = BOARD_DIM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  row,
    input  logic [2:0]  col,
    input  logic [63:0] mine_map,
    output logic        busy,
    output logic        done,
    output logic        is_mine,
    output logic [3:0]  count,
    output logic        nb_valid,
    output logic [2:0]  nb_row,
    output logic [2:0]  nb_col
);

    state_t      state;
    coord_t      lat_row;
    coord_t      lat_col;
    logic [63:0] lat_map;
    logic [2:0]  index;

    coord_t      calc_row;
    coord_t      calc_col;
    logic        calc_in;

    neighbor_offset #(
        .DIM(DIM)
    ) u_offset (
        .index    (index),
        .row      (lat_row),
        .col      (lat_col),
        .nb_row   (calc_row),
        .nb_col   (calc_col),
        .in_bounds(calc_in)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lat_row <= '0;
            lat_col <= '0;
            lat_map <= '0;
            index   <= '0;
            count   <= '0;
            is_mine <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lat_row <= row;
                        lat_col <= col;
                        lat_map <= mine_map;
                        count   <= '0;
                        is_mine <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (lat_map[{lat_row, lat_col}]) begin
                        is_mine <= 1'b1;
                        state   <= DONE;
                    end else begin
                        index <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (calc_in && lat_map[{calc_row, calc_col}])
                        count <= count + 4'd1;
                    index <= index + 3'd1;
                    if (index == 3'd7)
                        state <= DONE;
                end
                DONE: begin
                    // The pulse lands in the following IDLE cycle, which
                    // also accepts a fresh start.
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        nb_valid = (state == SCAN) && calc_in;
        nb_row   = (state == SCAN) ? calc_row : '0;
        nb_col   = (state == SCAN) ? calc_col : '0;
    end

endmodule

// File: tb/tb_neighbor_scan.sv
// Randomized bench for neighbor_scan against a direct adjacency-count model.
module tb_neighbor_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  row = '0;
    logic [2:0]  col = '0;
    logic [63:0] mine_map = '0;
    logic        busy;
    logic        done;
    logic        is_mine;
    logic [3:0]  count;
    logic        nb_valid;
    logic [2:0]  nb_row;
    logic [2:0]  nb_col;

    int vectors = 0;
    int miscompares = 0;

    neighbor_scan #(
        .DIM(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .row     (row),
        .col     (col),
        .mine_map(mine_map),
        .busy    (busy),
        .done    (done),
        .is_mine (is_mine),
        .count   (count),
        .nb_valid(nb_valid),
        .nb_row  (nb_row),
        .nb_col  (nb_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_count(input int r, input int c, input logic [63:0] m);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                    if (m[(r + dr) * 8 + (c + dc)]) n++;
        return n;
    endfunction

    function automatic int ref_onboard(input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                    n++;
        return n;
    endfunction

    // One request; with chaos set, inputs (including start) are scrambled while busy.
    task automatic do_scan(input int r, input int c, input logic [63:0] m, input bit chaos);
        int  cycles = 0;
        int  nbv = 0;
        bit  seen = 0;
        int  exp_mine = m[r * 8 + c] ? 1 : 0;
        int  exp_cnt = exp_mine ? 0 : ref_count(r, c, m);
        int  exp_lat = exp_mine ? 2 : 10;
        int  exp_nbv = exp_mine ? 0 : ref_onboard(r, c);
        @(negedge clk);
        start = 1'b1;
        row = 3'(r);
        col = 3'(c);
        mine_map = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        while (cycles < 20 && !seen) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                seen = 1;
                start = 1'b0;
            end else begin
                if (nb_valid) nbv++;
                if (chaos) begin
                    start = 1'($urandom);
                    row = 3'($urandom);
                    col = 3'($urandom);
                    mine_map = {$urandom, $urandom};
                end
            end
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", 32'(cycles), 32'(exp_lat));
            check("is_mine", 32'(is_mine), 32'(exp_mine));
            check("count", 32'(count), 32'(exp_cnt));
            check("nb_valid_cycles", 32'(nbv), 32'(exp_nbv));
            check("busy_at_done", 32'(busy), 0);
            @(posedge clk);
            #1;
            check("done_pulse_width", 32'(done), 0);
            check("no_queued_start", 32'(busy), 0);
            check("count_hold", 32'(count), 32'(exp_cnt));
            check("is_mine_hold", 32'(is_mine), 32'(exp_mine));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_is_mine"}, 32'(is_mine), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_nb_valid"}, 32'(nb_valid), 0);
        check({tag, "_nb_row"}, 32'(nb_row), 0);
        check({tag, "_nb_col"}, 32'(nb_col), 0);
    endtask

    initial begin
        logic [63:0] m;
        int r;
        int c;

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        m = '0;
        m[1] = 1'b1;
        m[8] = 1'b1;
        m[9] = 1'b1;
        do_scan(0, 0, m, 0);
        m = '1;
        m[27] = 1'b0;
        do_scan(3, 3, m, 0);
        m = '0;
        m[42] = 1'b1;
        do_scan(5, 2, m, 0);
        m = '0;
        m[0] = 1'b1;
        do_scan(7, 7, m, 0);
        m = '1;
        m[63] = 1'b0;
        do_scan(7, 7, m, 1);
        m = '1;
        m[0] = 1'b0;
        do_scan(0, 0, m, 1);

        // Abort at SCAN index 4, then a normal request.
        m = {$urandom, $urandom};
        m[4 * 8 + 4] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        row = 3'd4;
        col = 3'd4;
        mine_map = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_abort_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check_zero_outputs("abort");
        @(negedge clk);
        rst = 1'b1;
        m = {$urandom, $urandom};
        m[2 * 8 + 6] = 1'b0;
        do_scan(2, 6, m, 0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 7));
            c = int'($urandom_range(0, 7));
            m = {$urandom, $urandom};
            if (i % 3 == 0) m = m & {$urandom, $urandom};
            if (i % 5 == 0) m = m | {$urandom, $urandom};
            do_scan(r, c, m, (i % 2) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
